// File: rtl/flag_vend_sequencer.sv
// Passcode-gated flag streamer: collects code bytes from SW on BTNL presses, then either
// paces the flag ROM onto the display or enforces a timed lockout.
module flag_vend_sequencer #(
   parameter int unsigned CODE_LEN    = 4,
   parameter logic [31:0] CODE        = 32'h5952_4147,
   parameter int unsigned FLAG_LEN    = 32,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned LOCK_CYCLES = 8,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        SW,
   input  logic              BTNL,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic [7:0]        disp,
   output logic              busy,
   output logic              locked
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned LCNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_FETCH, S_SHOW, S_DONE, S_LOCK
   } state_t;

   state_t              state_q, state_d;
   logic                s1, s2, press;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          entry_q [4];
   logic [7:0]          entry_d [4];
   logic [ADDR_W-1:0]   idx_q, idx_d, rom_addr_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
   logic [7:0]          disp_d;
   logic                busy_d, locked_d, match;

   // One pulse per synchronized rising edge of the button.
   assign press = s1 & ~s2;

   // Only the first CODE_LEN slots take part in the comparison.
   always_comb begin
      match = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(CODE_LEN) && entry_q[i] != CODE[8*i +: 8]) match = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      entry_d    = entry_q;
      idx_d      = idx_q;
      hcnt_d     = hcnt_q;
      lcnt_d     = lcnt_q;
      rom_addr_d = rom_addr;
      disp_d     = disp;
      unique case (state_q)
         S_IDLE: begin
            if (press) begin
               entry_d[cnt_q[1:0]] = SW;
               cnt_d               = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(CODE_LEN)) state_d = S_CHECK;
            end
            disp_d = 8'(cnt_d);
         end
         S_CHECK: begin
            cnt_d   = '0;
            entry_d = '{default: '0};
            if (match) begin
               idx_d      = '0;
               rom_addr_d = '0;
               state_d    = S_FETCH;
            end else begin
               lcnt_d  = LCNT_W'(LOCK_CYCLES - 1);
               disp_d  = 8'hEE;
               state_d = S_LOCK;
            end
         end
         S_FETCH: begin
            disp_d  = rom_data;
            hcnt_d  = HCNT_W'(HOLD_CYCLES - 1);
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (hcnt_q != '0) begin
               hcnt_d = hcnt_q - HCNT_W'(1);
            end else if (idx_q == ADDR_W'(FLAG_LEN - 1)) begin
               disp_d  = 8'hFF;
               state_d = S_DONE;
            end else begin
               idx_d      = idx_q + ADDR_W'(1);
               rom_addr_d = idx_d;
               state_d    = S_FETCH;
            end
         end
         S_DONE: begin
            disp_d = 8'hFF;
            if (press) begin
               disp_d  = 8'h00;
               state_d = S_IDLE;
            end
         end
         S_LOCK: begin
            disp_d = 8'hEE;
            if (lcnt_q == '0) begin
               disp_d  = 8'h00;
               state_d = S_IDLE;
            end else begin
               lcnt_d = lcnt_q - LCNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d == S_CHECK) || (state_d == S_FETCH) || (state_d == S_SHOW);
      locked_d = (state_d == S_LOCK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         s1       <= 1'b0;
         s2       <= 1'b0;
         cnt_q    <= '0;
         entry_q  <= '{default: '0};
         idx_q    <= '0;
         hcnt_q   <= '0;
         lcnt_q   <= '0;
         rom_addr <= '0;
         disp     <= 8'h00;
         busy     <= 1'b0;
         locked   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s1       <= BTNL;
         s2       <= s1;
         cnt_q    <= cnt_d;
         entry_q  <= entry_d;
         idx_q    <= idx_d;
         hcnt_q   <= hcnt_d;
         lcnt_q   <= lcnt_d;
         rom_addr <= rom_addr_d;
         disp     <= disp_d;
         busy     <= busy_d;
         locked   <= locked_d;
      end
   end

endmodule
